// File: rtl/jk_pkg.sv
// jk_pkg: shared op/state encodings and the JK next-state function
package jk_pkg;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SET   = 3'd1;
  localparam logic [2:0] OP_CLR   = 3'd2;
  localparam logic [2:0] OP_TOG   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_COUNT = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_COUNT, S_DONE} state_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & k) ? ~q : j ? 1'b1 : k ? 1'b0 : q;
  endfunction

  function automatic logic is_apply(input logic [2:0] op);
    return op != OP_NOP && op < OP_COUNT;
  endfunction
endpackage

// File: rtl/jk_bit.sv
// jk_bit: single JK storage cell with async active-low clear
module jk_bit import jk_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  // hold / reset / set / toggle on each rising edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= jk_next(q, j, k);
endmodule

// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer driving J/K of a bank of JK cells
module jk_bank_ctrl import jk_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNTW-1:0]  cmd_count,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq,
  output logic             busy,
  output logic             done
);
  state_e state, state_nx;
  logic [2:0] op_r;
  logic [WIDTH-1:0] data_r, j, k, carry;
  logic [CNTW-1:0] cnt_r;
  logic accept;

  assign cmd_ready = state == S_IDLE;
  assign accept = cmd_valid & cmd_ready;
  assign busy = state == S_APPLY || state == S_COUNT;
  assign done = state == S_DONE;
  assign nq = ~q;

  // state register, command latch and remaining-step counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      op_r <= '0;
      data_r <= '0;
      cnt_r <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_r <= cmd_op;
        data_r <= cmd_data;
        cnt_r <= cmd_count;
      end else if (state == S_COUNT) cnt_r <= cnt_r - CNTW'(1);
    end

  // next state; leave COUNT on the edge that applies the last increment
  always_comb
    state_nx = state == S_IDLE ? (!accept ? S_IDLE :
                                  is_apply(cmd_op) ? S_APPLY :
                                  (cmd_op == OP_COUNT && cmd_count != '0) ? S_COUNT : S_DONE) :
               state == S_APPLY ? S_DONE :
               state == S_COUNT ? (cnt_r > CNTW'(1) ? S_COUNT : S_DONE) : S_IDLE;

  // toggle-enable chain for binary up-count: bit i toggles when all lower bits are 1
  always_comb begin
    carry = '0;
    carry[0] = 1'b1;
    for (int b = 1; b < WIDTH; b++) carry[b] = carry[b-1] & q[b-1];
  end

  // J/K decode; every state other than APPLY/COUNT holds
  always_comb begin
    j = state == S_COUNT ? carry :
        (state == S_APPLY && (op_r == OP_SET || op_r == OP_TOG || op_r == OP_LOAD)) ? data_r : '0;
    k = state == S_COUNT ? carry :
        state != S_APPLY ? '0 :
        (op_r == OP_CLR || op_r == OP_TOG) ? data_r :
        op_r == OP_LOAD ? ~data_r : '0;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_bit u_bit (.clk(clk), .rst(rst), .j(j[i]), .k(k[i]), .q(q[i]));
  end
endmodule

// File: doc/jk_bank_ctrl.md
# jk_bank_ctrl

Sequencing controller for a bank of JK flip-flops. It accepts register commands over a valid/ready handshake and drives per-bit J/K inputs for one or more clock edges: set, clear, toggle, load, or count N steps. It is the block that drives the JK storage cells in lab datapaths, so no other logic drives J/K directly.

## Interface
Clock `clk`; reset `rst`, asynchronous, active-low (asserted when `rst`=0).
- `WIDTH`, 4: number of JK bits in the bank (2..16).
- `CNTW`, 4: width of the count-step field.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  async active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command (high only in IDLE)
- `cmd_op`  in  3  0 NOP, 1 SET, 2 CLR, 3 TOG, 4 LOAD, 5 COUNT, 6–7 reserved (treated as NOP)
- `cmd_data`  in  WIDTH  bit mask for SET/CLR/TOG; value for LOAD; ignored otherwise
- `cmd_count`  in  CNTW  number of increments for COUNT
- `q`  out  WIDTH  flip-flop bank state
- `nq`  out  WIDTH  always `~q`
- `busy`  out  1  high in APPLY or COUNT
- `done`  out  1  one-cycle pulse when a command completes

## Operation
- Handshake: a command is accepted on a rising edge with `cmd_valid & cmd_ready`. At acceptance, `op`, `data` and `count` are latched into internal registers. Inputs are don't-care at all other times.
- States:
  - IDLE
    - NOP or reserved op → DONE.
    - op 1–4 → APPLY.
    - COUNT with count≠0 → COUNT.
    - COUNT with count=0 → DONE.
  - APPLY → DONE after exactly one edge.
  - COUNT
    - Stays while remaining > 1.
    - Moves to DONE on the edge that applies the last increment.
  - DONE → IDLE unconditionally.
- J/K drive by state:
  - APPLY, SET: J=mask, K=0.
  - APPLY, CLR: J=0, K=mask.
  - APPLY, TOG: J=K=mask.
  - APPLY, LOAD: J=data, K=~data.
  - COUNT: J[i]=K[i]=&q[i-1:0], with J[0]=K[0]=1. This gives a binary up-count that wraps from all-ones to 0.
  - All other states: J=K=0 (hold).
- The remaining-count register decrements on each COUNT edge.
- Bits outside the mask are unchanged.
- Arithmetic is modulo 2^WIDTH. Wrap-around is not flagged.

## Timing
- Reset values: `q`=0, `nq`=all-ones, state=IDLE, `cmd_ready`=1, `busy`=0, `done`=0. Internal registers are cleared.
- Reset mid-command aborts immediately. No `done` is produced for the aborted command.
- Accept at edge E0. For op 1–4, `q` updates at E1 and `done`=1 during E1–E2. `cmd_ready` returns to 1 after E2. Throughput is one command per 3 cycles.
- COUNT with n≥1: increments at E1..En, `done` during En–En+1, `cmd_ready` high after En+1.
- NOP, reserved op, or COUNT 0: `q` unchanged, `done` during E1–E2.
- `cmd_valid` held high while `cmd_ready`=0 is ignored and not queued. The command is accepted on the first edge where `cmd_ready`=1.
- `busy` and `cmd_ready` are registered-state decodes, not combinational from inputs.

## Structure
- Shared package `jk_pkg` holds:
  - the op encodings (`OP_NOP`..`OP_COUNT`),
  - the state encoding (IDLE, APPLY, COUNT, DONE),
  - the JK next-state function: hold, reset, set, toggle.
- Sub-module `jk_bit`: one JK cell with async active-low clear, instantiated WIDTH times via generate.
- The controller holds:
  - the FSM,
  - the latched command registers,
  - the J/K decode.

## Test plan
- Reset held low for 2 cycles with random `cmd_*` → `q`=0000, `nq`=1111, `cmd_ready`=1, `done`=0. Release reset → nothing changes until a command is sent.
- Send LOAD 1010 → `q`=1010 one edge after accept, `done` pulses for 1 cycle. Then TOG 0110 → `q`=1100. Then CLR 1000 → `q`=0100. Then SET 0001 → `q`=0101.
- From `q`=1101, COUNT 5 → `q` steps 1110, 1111, 0000, 0001, 0010 (wraps), `busy`=1 for 5 cycles, single `done`. COUNT 0 → `q` unchanged, `done` one edge after accept.
- Hold `cmd_valid`=1 with back-to-back LOAD 0011 then LOAD 1100 → the second command is accepted only when `cmd_ready`=1, 3 cycles after the first. Final `q`=1100.
- Reserved op 6 with data 1111 → `q` unchanged, `done` pulses, `busy` stays 0.
- Assert `rst` low asynchronously mid-COUNT 8, between clock edges → `q`=0000 immediately, no `done`. After release, state=IDLE and `cmd_ready`=1.
